bridge_buffer_ctrl: RTL and testbench

BRIDGE_BUFFER_CTRL -- requirements
Module: bridge_buffer_ctrl

---
 rtl/bridge_buf_pkg.sv | 15 +
 rtl/bridge_addr_cnt.sv | 28 ++
 rtl/bridge_buffer_ctrl.sv | 158 +++++++++++++++
 tb/tb_bridge_buffer_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bridge_buf_pkg.sv
// Shared types and default sizing for the bridge buffer controller.
package bridge_buf_pkg;

  localparam int unsigned DEF_ADDR_WIDTH    = 8;
  localparam int unsigned DEF_DEPTH         = 16;
  localparam int unsigned DEF_TOTAL_MODULES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } bridge_ctrl_state_t;

endpackage

// File: rtl/bridge_addr_cnt.sv
// Wrapping up-counter 0..MAX_VAL with enable, sync clear and terminal flag.
module bridge_addr_cnt #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             last_c
);

  // Terminal value reached; the next enabled step wraps to zero.
  assign last_c = (cnt == WIDTH'(MAX_VAL));

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last_c ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bridge_buffer_ctrl.sv
// Bridge buffer controller: fills a DEPTH-word buffer, then drains it
// TOTAL_MODULES times (one pass per slice) through a valid/ready output.
// Optional busy-cycle counter enabled by defining BRIDGE_BUFFER_CTRL_PERF_EN.
module bridge_buffer_ctrl
  import bridge_buf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned DEPTH         = DEF_DEPTH,
  parameter int unsigned TOTAL_MODULES = DEF_TOTAL_MODULES,
  localparam int unsigned SW           = $clog2(TOTAL_MODULES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef BRIDGE_BUFFER_CTRL_PERF_EN
  output logic [31:0]           perf_cycles,
`endif
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  w_ena,
  output logic                  w_wea,
  output logic                  w_enb,
  output logic                  w_web,
  output logic [ADDR_WIDTH-1:0] w_addra,
  output logic [ADDR_WIDTH-1:0] w_addrb,
  output logic                  n_wr_en,
  output logic                  n_rd_en,
  output logic [ADDR_WIDTH-1:0] n_wr_addr,
  output logic [ADDR_WIDTH-1:0] n_rd_addr,
  output logic [SW-1:0]         w_slicing_idx,
  output logic [SW-1:0]         n_slicing_idx,
  output logic                  out_valid,
  input  logic                  out_ready
);

  bridge_ctrl_state_t state_q, state_d;

  logic                  start_acc_c;
  logic                  wr_fire_c;
  logic                  rd_issue_c;
  logic                  flush_end_c;
  logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt;
  logic [SW-1:0]         slice_cnt;
  logic                  wr_last_c, rd_last_c, slice_last_c;
  logic [ADDR_WIDTH-1:0] w_addr_q, n_wr_addr_q, n_rd_addr_q;
  logic [SW-1:0]         slice_q;

  assign start_acc_c = (state_q == IDLE) && start;
  assign flush_end_c = (state_q == FLUSH) && (!out_valid || out_ready);

  // Write address counter.
  bridge_addr_cnt #(.WIDTH(ADDR_WIDTH), .MAX_VAL(DEPTH - 1)) u_wr_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_acc_c), .en(wr_fire_c),
    .cnt(wr_cnt), .last_c(wr_last_c)
  );

  // Read address counter (inner loop).
  bridge_addr_cnt #(.WIDTH(ADDR_WIDTH), .MAX_VAL(DEPTH - 1)) u_rd_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_acc_c), .en(rd_issue_c),
    .cnt(rd_cnt), .last_c(rd_last_c)
  );

  // Slice counter (outer loop), steps when the read address wraps.
  bridge_addr_cnt #(.WIDTH(SW), .MAX_VAL(TOTAL_MODULES - 1)) u_slice_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_acc_c), .en(rd_issue_c && rd_last_c),
    .cnt(slice_cnt), .last_c(slice_last_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FILL;
      FILL:  if (wr_fire_c && wr_last_c) state_d = DRAIN;
      DRAIN: if (rd_issue_c && rd_last_c && slice_last_c) state_d = FLUSH;
      FLUSH: if (flush_end_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer-port decode; idle addresses replay their last driven value.
  always_comb begin
    busy       = (state_q != IDLE);
    in_ready   = (state_q == FILL);
    wr_fire_c  = in_ready && in_valid;
    rd_issue_c = (state_q == DRAIN) && (!out_valid || out_ready);
    w_ena      = wr_fire_c || rd_issue_c;
    w_wea      = wr_fire_c;
    n_wr_en    = wr_fire_c;
    n_rd_en    = rd_issue_c;
    w_addra    = w_addr_q;
    n_wr_addr  = n_wr_addr_q;
    n_rd_addr  = n_rd_addr_q;
    if (wr_fire_c) begin
      w_addra   = wr_cnt;
      n_wr_addr = wr_cnt;
    end
    if (rd_issue_c) begin
      w_addra   = rd_cnt;
      n_rd_addr = rd_cnt;
    end
  end

  assign w_enb         = 1'b0;
  assign w_web         = 1'b0;
  assign w_addrb       = '0;
  assign w_slicing_idx = slice_q;
  assign n_slicing_idx = slice_q;

  // Held addresses, output-side valid/slice tracking and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr_q    <= '0;
      n_wr_addr_q <= '0;
      n_rd_addr_q <= '0;
      slice_q     <= '0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
    end else begin
      w_addr_q    <= w_addra;
      n_wr_addr_q <= n_wr_addr;
      n_rd_addr_q <= n_rd_addr;
      done        <= flush_end_c;
      if (rd_issue_c) begin
        out_valid <= 1'b1;
        slice_q   <= slice_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef BRIDGE_BUFFER_CTRL_PERF_EN
  logic [31:0] perf_cnt;

  // Busy-cycle counter, latched into perf_cycles when the job completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else if (flush_end_c) begin
      perf_cycles <= perf_cnt + 32'd1;
      perf_cnt    <= '0;
    end else if (busy) begin
      perf_cnt    <= perf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bridge_buffer_ctrl.sv
// Directed table-driven bench for bridge_buffer_ctrl (DEPTH=4, TOTAL_MODULES=2).
module tb_bridge_buffer_ctrl;

  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic busy, done, in_ready, w_ena, w_wea, w_enb, w_web, n_wr_en, n_rd_en, out_valid;
  logic [AW-1:0] w_addra, w_addrb, n_wr_addr, n_rd_addr;
  logic [0:0] w_slicing_idx, n_slicing_idx;
`ifdef BRIDGE_BUFFER_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  bridge_buffer_ctrl #(.ADDR_WIDTH(AW), .DEPTH(4), .TOTAL_MODULES(2)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef BRIDGE_BUFFER_CTRL_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready),
    .w_ena(w_ena), .w_wea(w_wea), .w_enb(w_enb), .w_web(w_web),
    .w_addra(w_addra), .w_addrb(w_addrb),
    .n_wr_en(n_wr_en), .n_rd_en(n_rd_en),
    .n_wr_addr(n_wr_addr), .n_rd_addr(n_rd_addr),
    .w_slicing_idx(w_slicing_idx), .n_slicing_idx(n_slicing_idx),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy, in_ready, w_ena, w_wea, w_enb, w_web, n_wr_en, n_rd_en;
    logic [AW-1:0] w_addra, w_addrb, n_wr_addr, n_rd_addr;
    logic          w_sl, n_sl, ov, done;
  } obs_t;

  typedef struct {
    logic start, in_valid, out_ready;
    obs_t exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.in_ready = in_ready; o.w_ena = w_ena; o.w_wea = w_wea;
    o.w_enb = w_enb; o.w_web = w_web; o.n_wr_en = n_wr_en; o.n_rd_en = n_rd_en;
    o.w_addra = w_addra; o.w_addrb = w_addrb; o.n_wr_addr = n_wr_addr; o.n_rd_addr = n_rd_addr;
    o.w_sl = w_slicing_idx; o.n_sl = n_slicing_idx; o.ov = out_valid; o.done = done;
    return o;
  endfunction

  // s,iv,ordy | busy,in_ready,w_ena,w_wea,n_wr_en,n_rd_en | w_addra,n_wr_addr,n_rd_addr,slice,out_valid,done
  function automatic vec_t mk(input logic s, iv, ordy, b, ir, en, we, nw, nr,
                              input int wa, nwa, nra, sl, ov, dn);
    vec_t v;
    v.start = s; v.in_valid = iv; v.out_ready = ordy;
    v.exp = '0;
    v.exp.busy = b; v.exp.in_ready = ir; v.exp.w_ena = en; v.exp.w_wea = we;
    v.exp.n_wr_en = nw; v.exp.n_rd_en = nr;
    v.exp.w_addra = AW'(wa); v.exp.n_wr_addr = AW'(nwa); v.exp.n_rd_addr = AW'(nra);
    v.exp.w_sl = 1'(sl); v.exp.n_sl = 1'(sl); v.exp.ov = 1'(ov); v.exp.done = 1'(dn);
    return v;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // One vector per cycle: drive at negedge, compare after settle.
  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      start = tbl[i].start; in_valid = tbl[i].in_valid; out_ready = tbl[i].out_ready;
      #1;
      check_obs($sformatf("%s[%0d]", name, i), sample(), tbl[i].exp);
    end
    tbl.delete();
  endtask

  // Full job, in_valid and out_ready held high, starting from zeroed addresses.
  task automatic load_job1();
    tbl.push_back(mk(1,1,1, 0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1, 1,1,1,1,1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1, 1,1,1,1,1,0, 1,1,0,0,0,0));
    tbl.push_back(mk(0,1,1, 1,1,1,1,1,0, 2,2,0,0,0,0));
    tbl.push_back(mk(0,1,1, 1,1,1,1,1,0, 3,3,0,0,0,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 0,3,0,0,0,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 1,3,1,0,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 2,3,2,0,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 3,3,3,0,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 0,3,0,0,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 1,3,1,1,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 2,3,2,1,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 3,3,3,1,1,0));
    tbl.push_back(mk(0,0,1, 1,0,0,0,0,0, 3,3,3,1,1,0));
    tbl.push_back(mk(0,0,1, 0,0,0,0,0,0, 3,3,3,1,0,1));
    tbl.push_back(mk(0,0,1, 0,0,0,0,0,0, 3,3,3,1,0,0));
  endtask

  // Toggled in_valid fill, 3-cycle stall on read 2, start retried in DRAIN.
  task automatic load_job2();
    tbl.push_back(mk(1,0,1, 0,0,0,0,0,0, 3,3,3,1,0,0));
    tbl.push_back(mk(0,1,1, 1,1,1,1,1,0, 0,0,3,1,0,0));
    tbl.push_back(mk(0,0,1, 1,1,0,0,0,0, 0,0,3,1,0,0));
    tbl.push_back(mk(0,1,1, 1,1,1,1,1,0, 1,1,3,1,0,0));
    tbl.push_back(mk(0,0,1, 1,1,0,0,0,0, 1,1,3,1,0,0));
    tbl.push_back(mk(0,1,1, 1,1,1,1,1,0, 2,2,3,1,0,0));
    tbl.push_back(mk(0,0,1, 1,1,0,0,0,0, 2,2,3,1,0,0));
    tbl.push_back(mk(0,1,1, 1,1,1,1,1,0, 3,3,3,1,0,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 0,3,0,1,0,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 1,3,1,0,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 2,3,2,0,1,0));
    tbl.push_back(mk(0,0,0, 1,0,0,0,0,0, 2,3,2,0,1,0));
    tbl.push_back(mk(1,0,0, 1,0,0,0,0,0, 2,3,2,0,1,0));
    tbl.push_back(mk(0,0,0, 1,0,0,0,0,0, 2,3,2,0,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 3,3,3,0,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 0,3,0,0,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 1,3,1,1,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 2,3,2,1,1,0));
    tbl.push_back(mk(0,0,1, 1,0,1,0,0,1, 3,3,3,1,1,0));
    tbl.push_back(mk(0,0,1, 1,0,0,0,0,0, 3,3,3,1,1,0));
    tbl.push_back(mk(0,0,1, 0,0,0,0,0,0, 3,3,3,1,0,1));
  endtask

  initial begin
    obs_t zero_obs;
    obs_t cur;
    zero_obs = '0;

    #1;
    check_obs("reset_state", sample(), zero_obs);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    load_job1();
    run_table("job1");
`ifdef BRIDGE_BUFFER_CTRL_PERF_EN
    check_val("perf_job1", perf_cycles, 32'd13);
`endif

    load_job2();
    run_table("job2");
`ifdef BRIDGE_BUFFER_CTRL_PERF_EN
    check_val("perf_job2", perf_cycles, 32'd19);
`endif

    // Abort a job mid-DRAIN with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    cur = sample();
    check_val("pre_abort_drain", {31'd0, cur.ov & cur.n_rd_en & cur.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_obs("async_reset_outputs", sample(), zero_obs);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_obs($sformatf("held_reset[%0d]", i), sample(), zero_obs);
    end
    rst_n = 1'b1;

    // Fresh job after the abort must run from address 0, slice 0.
    load_job1();
    run_table("job_after_abort");
`ifdef BRIDGE_BUFFER_CTRL_PERF_EN
    check_val("perf_after_abort", perf_cycles, 32'd13);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
